// File: rtl/cell_alloc.sv
// Fixed-size cell heap allocator: bump pointer for fresh cells plus a LIFO free
// list threaded through the low ADDR_SZ bits of each freed cell.
module cell_alloc #(
  parameter int ADDR_SZ = 8,
  parameter int DATA_SZ = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_alloc,
  input  logic               i_free,
  input  logic               i_rd,
  input  logic               i_wr,
  input  logic [ADDR_SZ-1:0] i_addr,
  input  logic [DATA_SZ-1:0] i_data,
  output logic               o_ready,
  output logic               o_valid,
  output logic [ADDR_SZ-1:0] o_addr,
  output logic [DATA_SZ-1:0] o_data,
  output logic               o_full,
  output logic [ADDR_SZ-1:0] o_count,
  output logic               o_error
);

  typedef enum logic [1:0] {IDLE = 2'd0, LINK = 2'd1, DONE = 2'd2} state_t;

  localparam logic [ADDR_SZ-1:0] ONE = ADDR_SZ'(1);

  state_t             state;
  logic [DATA_SZ-1:0] mem [0:(1<<ADDR_SZ)-1];
  logic [ADDR_SZ-1:0] mem_top;
  logic [ADDR_SZ-1:0] mem_next;
  logic [ADDR_SZ-1:0] link_q;
  logic [DATA_SZ-1:0] data_q;

  logic [3:0]         strobes;
  logic               single;
  logic               multi;
  logic               addr_bad;
  logic               mem_we;
  logic [ADDR_SZ-1:0] waddr;
  logic [DATA_SZ-1:0] wdata;

  assign strobes  = {i_alloc, i_free, i_rd, i_wr};
  assign single   = $onehot(strobes);
  assign multi    = (strobes != 4'b0000) && !single;
  assign addr_bad = (i_addr == '0) || ((mem_top != '0) && (i_addr >= mem_top));
  assign o_full   = (mem_next == '0) && (mem_top == '0);

  // RAM write port selection: LINK completes a free-list alloc, otherwise the accepted request
  always_comb begin
    mem_we = 1'b0;
    waddr  = i_addr;
    wdata  = i_data;
    if (state == LINK) begin
      mem_we = 1'b1;
      waddr  = mem_next;
      wdata  = data_q;
    end else if (o_ready && single) begin
      if (i_alloc) begin
        if ((mem_next == '0) && (mem_top != '0)) begin
          mem_we = 1'b1;
          waddr  = mem_top;
        end else begin
          mem_we = 1'b0;
        end
      end else if (i_free) begin
        mem_we = !addr_bad;
        wdata  = DATA_SZ'(mem_next);
      end else if (i_wr) begin
        mem_we = !addr_bad;
      end else begin
        mem_we = 1'b0;
      end
    end else begin
      mem_we = 1'b0;
    end
  end

  // Cell storage; contents survive reset
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[waddr] <= wdata;
    end
  end

  // Request FSM, allocator bookkeeping and registered result outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_addr   <= '0;
      o_data   <= '0;
      o_count  <= '0;
      o_error  <= 1'b0;
      mem_top  <= ONE;
      mem_next <= '0;
      link_q   <= '0;
      data_q   <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        LINK: begin
          o_addr   <= mem_next;
          mem_next <= link_q;
          o_count  <= o_count + ONE;
          o_valid  <= 1'b1;
          o_ready  <= 1'b1;
          state    <= DONE;
        end
        IDLE, DONE: begin
          state   <= IDLE;
          o_ready <= 1'b1;
          if (multi) begin
            o_error <= 1'b1;
            o_valid <= 1'b1;
            o_addr  <= '0;
            o_data  <= '0;
            state   <= DONE;
          end else if (single) begin
            o_valid <= 1'b1;
            o_addr  <= i_addr;
            o_data  <= '0;
            state   <= DONE;
            if (i_alloc) begin
              if (mem_next != '0) begin
                // Head's link comes out of the RAM next cycle; finish in LINK
                link_q  <= mem[mem_next][ADDR_SZ-1:0];
                data_q  <= i_data;
                o_valid <= 1'b0;
                o_ready <= 1'b0;
                state   <= LINK;
              end else if (mem_top != '0) begin
                o_addr  <= mem_top;
                mem_top <= mem_top + ONE;
                o_count <= o_count + ONE;
              end else begin
                o_addr  <= '0;
                o_error <= 1'b1;
              end
            end else if (addr_bad) begin
              o_error <= 1'b1;
            end else if (i_free) begin
              mem_next <= i_addr;
              o_count  <= o_count - ONE;
            end else if (i_rd) begin
              o_data <= mem[i_addr];
            end else begin
              o_data <= '0;
            end
          end else begin
            state <= state;
          end
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cell_alloc.sv
// Directed scoreboard bench for cell_alloc with ADDR_SZ=3 so the heap can be
// exhausted; expectations come from a behavioural free-stack model.
module tb_cell_alloc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_alloc = 1'b0, i_free = 1'b0, i_rd = 1'b0, i_wr = 1'b0;
  logic [2:0]  i_addr = 3'd0;
  logic [15:0] i_data = 16'h0000;
  logic        o_ready, o_valid, o_full, o_error;
  logic [2:0]  o_addr, o_count;
  logic [15:0] o_data;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    logic [2:0]  count;
    logic        err;
    logic        full;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          m_top;
  int          m_cnt;
  logic        m_err;
  logic [2:0]  m_stack[$];
  logic [15:0] m_mem[8];

  cell_alloc #(.ADDR_SZ(3), .DATA_SZ(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_alloc(i_alloc), .i_free(i_free), .i_rd(i_rd), .i_wr(i_wr),
    .i_addr(i_addr), .i_data(i_data),
    .o_ready(o_ready), .o_valid(o_valid), .o_addr(o_addr), .o_data(o_data),
    .o_full(o_full), .o_count(o_count), .o_error(o_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_top = 1;
    m_cnt = 0;
    m_err = 1'b0;
    m_stack.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(o_ready), 32'd1);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_addr"},  32'(o_addr),  32'd0);
    chk({tag, "_data"},  32'(o_data),  32'd0);
    chk({tag, "_full"},  32'(o_full),  32'd0);
    chk({tag, "_count"}, 32'(o_count), 32'd0);
    chk({tag, "_error"}, 32'(o_error), 32'd0);
  endtask

  task automatic model(input logic a, f, r, w, input logic [2:0] ad,
                       input logic [15:0] d, output exp_t e);
    logic [2:0] x;
    logic       bad;
    int         n;
    n      = int'(a) + int'(f) + int'(r) + int'(w);
    bad    = (ad == 3'd0) || ((m_top != 0) && (int'(ad) >= m_top));
    e.lat  = 1;
    e.addr = ad;
    e.data = 16'h0000;
    if (n > 1) begin
      m_err  = 1'b1;
      e.addr = 3'd0;
    end else if (a) begin
      if (m_stack.size() > 0) begin
        x = m_stack.pop_back();
        e.addr = x;
        m_mem[x] = d;
        m_cnt++;
        e.lat = 2;
      end else if (m_top != 0) begin
        e.addr = 3'(m_top);
        m_mem[m_top] = d;
        m_top = (m_top + 1) % 8;
        m_cnt++;
      end else begin
        e.addr = 3'd0;
        m_err  = 1'b1;
      end
    end else if (bad) begin
      m_err = 1'b1;
    end else if (f) begin
      m_mem[ad] = (m_stack.size() > 0) ? {13'd0, m_stack[m_stack.size()-1]} : 16'h0000;
      m_stack.push_back(ad);
      m_cnt--;
    end else if (r) begin
      e.data = m_mem[ad];
    end else if (w) begin
      m_mem[ad] = d;
    end
    e.count = 3'(m_cnt);
    e.err   = m_err;
    e.full  = (m_stack.size() == 0) && (m_top == 0);
  endtask

  task automatic req(input string tag, input logic a, f, r, w,
                     input logic [2:0] ad, input logic [15:0] d);
    exp_t e;
    exp_t got;
    int   cyc;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(o_ready), 32'd1);
    chk({tag, "_valid_idle"}, 32'(o_valid), 32'd0);
    model(a, f, r, w, ad, d, e);
    sb.push_back(e);
    i_alloc = a; i_free = f; i_rd = r; i_wr = w;
    i_addr = ad; i_data = d;
    @(posedge clk);
    #1;
    i_alloc = 1'b0; i_free = 1'b0; i_rd = 1'b0; i_wr = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!o_valid && cyc == 1 && e.lat == 2) chk({tag, "_ready_link"}, 32'(o_ready), 32'd0);
    end while (!o_valid && cyc < 6);
    chk({tag, "_latency"}, 32'(cyc), 32'(e.lat));
    got = sb.pop_front();
    chk({tag, "_addr"},  32'(o_addr),  32'(got.addr));
    chk({tag, "_data"},  32'(o_data),  32'(got.data));
    chk({tag, "_count"}, 32'(o_count), 32'(got.count));
    chk({tag, "_error"}, 32'(o_error), 32'(got.err));
    chk({tag, "_full"},  32'(o_full),  32'(got.full));
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    req("alloc1", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h1111);
    req("alloc2", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h2222);
    req("alloc3", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h3333);
    req("rd1",    1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 16'h0000);
    req("free2",  1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0000);
    req("realloc2", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'hABCD);
    req("rd2",    1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 16'h0000);
    req("free3",  1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 16'h0000);
    req("free1",  1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 16'h0000);
    req("rd1_link", 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 16'h0000);
    req("lifo1",  1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h4141);
    req("lifo3",  1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h4343);
    req("bump4",  1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h4444);
    req("wr4",    1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 16'h5555);
    req("rd4",    1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 16'h0000);
    req("rd3",    1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 16'h0000);
    req("alloc5", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0505);
    req("alloc6", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0606);
    req("alloc7", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0707);
    req("alloc_full", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0808);
    req("free5",  1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 16'h0000);
    req("rd5_link", 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 16'h0000);
    req("rd_nil", 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000);
    req("multi",  1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 16'h9999);
    req("rd7",    1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 16'h0000);

    // Reset while the free-list alloc sits in LINK
    @(negedge clk);
    i_alloc = 1'b1; i_data = 16'h7777;
    @(posedge clk);
    #1;
    i_alloc = 1'b0;
    @(negedge clk);
    chk("link_ready", 32'(o_ready), 32'd0);
    chk("link_valid", 32'(o_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset("mid_reset");
    @(posedge clk);
    #1;
    chk("mid_reset_no_valid", 32'(o_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    req("post_reset_alloc", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'hBEEF);
    req("post_reset_rd1", 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 16'h0000);
    req("post_reset_rd_bad", 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 16'h0000);
    req("sticky_err", 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cell_alloc.md
Name: cell_alloc

Overview:
Fixed-size cell heap allocator with a free list. It is the responder that the alloc_test fixture drives.
- Serves alloc, free, read and write requests against an internal synchronous RAM of cells.
- Address 0 is NIL and is never handed out. Fresh cells come from a bump pointer; freed cells are chained through their own data word.
- Sits between a core or test fixture and one iCE40 BRAM.

Parameters:
ADDR_SZ, 8, cell address width; cells 1..2**ADDR_SZ-1 are usable.
DATA_SZ, 16, cell data width; must be >= ADDR_SZ, because a free-list link is stored in the low ADDR_SZ bits.

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_alloc  in  1  request: allocate a cell and write i_data into it
i_free  in  1  request: release cell i_addr
i_rd  in  1  request: read cell i_addr
i_wr  in  1  request: write i_data to cell i_addr
i_addr  in  ADDR_SZ  target cell for free/rd/wr
i_data  in  DATA_SZ  write data for alloc/wr
o_ready  out  1  idle; a request strobe is accepted this cycle
o_valid  out  1  one-cycle pulse; the result of the accepted request is present
o_addr  out  ADDR_SZ  allocated cell (alloc), else echo of i_addr; 0 on failed alloc
o_data  out  DATA_SZ  read data (rd), else 0
o_full  out  1  no free cells: free list empty and bump pointer exhausted
o_count  out  ADDR_SZ  number of cells currently in use
o_error  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (async, i_rst_n=0):
  - o_ready=1; o_valid=0, o_addr=0, o_data=0, o_full=0, o_count=0, o_error=0.
  - Internal mem_top=1 (next never-used cell), mem_next=0 (free-list head, 0 = empty).
  - RAM contents are not cleared.
- Request acceptance:
  - A request is accepted on a rising edge where o_ready=1 and exactly one strobe is high.
  - Two or more strobes high together: no operation, o_error<=1, o_valid pulses next cycle with o_addr=0.
  - Strobes while o_ready=0 are ignored; they are neither queued nor counted as errors.
- FSM states: IDLE, LINK, DONE.
  - IDLE: o_ready=1.
  - alloc with mem_next!=0: RAM read of mem_next, go to LINK, o_ready=0.
    - LINK: o_addr<=mem_next; mem_next<=link read from RAM; write i_data (latched at accept) to the cell; go to DONE.
    - DONE: o_valid=1, o_ready=1, return to IDLE behaviour (a new request may be accepted in DONE).
    - Latency: o_valid 2 cycles after accept.
  - alloc with mem_next=0 and mem_top!=0:
    - o_addr<=mem_top; write i_data to the cell; mem_top<=mem_top+1.
    - mem_top wraps to 0 at 2**ADDR_SZ, meaning exhausted.
    - o_valid the cycle after accept.
  - alloc when full: o_addr=0, o_error<=1, o_valid the cycle after accept, no state change.
  - free: write mem_next into the cell's low ADDR_SZ bits (upper bits zero); mem_next<=i_addr; o_count-1. o_valid the cycle after accept.
  - rd: o_data = RAM[i_addr], o_valid the cycle after accept.
  - wr: RAM[i_addr]<=i_data, o_valid the cycle after accept.
- Successful alloc: o_count+1, updated in the same cycle o_valid is asserted.
- Address check for free/rd/wr:
  - Invalid if i_addr==0 or (mem_top!=0 and i_addr>=mem_top).
  - Invalid address: o_error<=1, no memory or list change, o_valid still pulses.
- Double free is not detected; behaviour is undefined.
- o_full is combinational on registered state: (mem_next==0) && (mem_top==0).
- Reset asserted mid-operation, including in LINK: return immediately to the reset state; no o_valid for the aborted request.

Test Plan:
- Reset, then 3 allocs with data 16'h1111, 16'h2222, 16'h3333 -> o_addr=1,2,3; each o_valid 1 cycle after accept; o_count=3; o_error=0.
- Free 2, then alloc data 16'hABCD -> free acks with o_count=2; alloc returns o_addr=2 with o_valid 2 cycles after accept; o_ready=0 during LINK; o_count=3; rd 2 returns 16'hABCD.
- Free 3 then free 1, then two allocs -> LIFO reuse: returns 1 then 3; then next alloc returns 4 (bump).
- ADDR_SZ=3: 7 allocs return 1..7, o_full=1 after the 7th; 8th alloc -> o_addr=0, o_error=1; free 5 -> o_full=0.
- i_alloc and i_rd high together, and rd of address 0 -> no state change, o_valid pulses, o_error=1, and o_error stays 1 until reset.
- Assert i_rst_n=0 during LINK -> outputs at reset values immediately, no o_valid; after release, alloc returns 1.
